// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch slice: default widths, enable
// levels, zero words and the per-slot PC increment.
package if_fetch_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_INST_W = 64;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic [63:0] ZeroDoubleWord = 64'h0;

    localparam int PC_INC        = 8;
    localparam int PC_ALIGN_MASK = 7;

    localparam logic [1:0] BUF_DEPTH = 2'd2;

    // An instruction slot is 8 bytes, so only the low three bits matter.
    function automatic logic pc_aligned(input logic [2:0] lo);
        return (lo == 3'b000);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's ROM, redirect and decode-handshake signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 64
);
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              misalign_o;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, misalign_o,
        input  rom_inst_i, stall_i, redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, misalign_o,
        output rom_inst_i, stall_i, redirect_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/if_fetch_buf.sv
// Two-entry {pc, inst} fetch buffer. Entry 0 is always the head; a pop shifts
// entry 1 down. Head outputs read zero when the buffer is empty.
module if_fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int INST_W = IF_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [INST_W-1:0] head_inst_o
);

    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic              pop_ok, push_ok;
    logic [1:0]        wr_idx;

    always_comb begin
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != BUF_DEPTH) || pop_ok);
        wr_idx  = count_q - {1'b0, pop_ok};
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (clear_i) begin
            count_d = 2'd0;
        end

        pc0_d   = pc0_q;
        inst0_d = inst0_q;
        pc1_d   = pc1_q;
        inst1_d = inst1_q;
        if (pop_ok) begin
            pc0_d   = pc1_q;
            inst0_d = inst1_q;
        end
        // New entry lands just behind whatever survives this cycle's pop.
        if (push_ok) begin
            if (wr_idx == 2'd0) begin
                pc0_d   = push_pc_i;
                inst0_d = push_inst_i;
            end else begin
                pc1_d   = push_pc_i;
                inst1_d = push_inst_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc0_q   <= pc0_d;
        inst0_q <= inst0_d;
        pc1_q   <= pc1_d;
        inst1_q <= inst1_d;
    end

    assign count_o     = count_q;
    assign valid_o     = (count_q != 2'd0);
    assign head_pc_o   = valid_o ? pc0_q   : '0;
    assign head_inst_o = valid_o ? inst0_q : '0;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, ROM chip enable, fetch gating and redirects.
// Optional feature macro IF_ALIGN_CHECK_EN flags misaligned redirects instead of masking them.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INST_W   = IF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    logic              misalign;
    logic [ADDR_W-1:0] redir_pc;
    logic [1:0]        count;
    logic              buf_valid;
    logic              pop;
    logic              fetch;

    assign pop   = buf_valid && bus.id_ready_i;
    assign fetch = ce_q && !bus.stall_i && !bus.redirect_i && !misalign &&
                   ((count != BUF_DEPTH) || pop);

`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (bus.redirect_i) begin
            misalign_d = !pc_aligned(bus.redirect_pc_i[2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign redir_pc = bus.redirect_pc_i;
    assign misalign = misalign_q;
`else
    // Without the check, a misaligned target snaps down to its slot.
    assign redir_pc = bus.redirect_pc_i & ~ADDR_W'(PC_ALIGN_MASK);
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_i) begin
            pc_d = redir_pc;
        end else if (fetch) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q <= RESET_PC;
            ce_q <= ChipDisable;
        end else begin
            pc_q <= pc_d;
            ce_q <= ChipEnable;
        end
    end

    if_fetch_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (bus.redirect_i),
        .push_i      (fetch),
        .push_pc_i   (pc_q),
        .push_inst_i (bus.rom_inst_i),
        .pop_i       (pop),
        .count_o     (count),
        .valid_o     (buf_valid),
        .head_pc_o   (bus.id_pc_o),
        .head_inst_o (bus.id_inst_o)
    );

    assign bus.rom_ce_o   = ce_q;
    assign bus.rom_addr_o = pc_q;
    assign bus.id_valid_o = buf_valid;
    assign bus.misalign_o = misalign;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: per-cycle vector table plus a scoreboard of accepted
// {pc, inst} pairs checked in order at the decode handshake.
module tb_if_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;

    always #5 clk = ~clk;

    if_fetch_if #(.ADDR_W(32), .INST_W(64)) bus ();

    if_fetch #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        return {32'hC0DE_0000 ^ (a >> 3), ~a};
    endfunction

    always_comb begin
        bus.rom_inst_i = bus.rom_ce_o ? rom_word(bus.rom_addr_o) : 64'h0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, rdy, stall, redir;
        logic [31:0] rpc;
        logic        acc;
        logic [31:0] apc;
        logic        ece;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic        emis;
    } row_t;

    row_t        tv[$];
    logic [31:0] sb[$];

    function automatic row_t mk(input logic r, input logic rd, input logic st, input logic rdir,
                                input logic [31:0] rpc, input logic acc, input logic [31:0] apc,
                                input logic ce, input logic [31:0] addr, input logic vld,
                                input logic [31:0] pc, input logic mis);
        row_t t;
        t.rst = r; t.rdy = rd; t.stall = st; t.redir = rdir; t.rpc = rpc;
        t.acc = acc; t.apc = apc;
        t.ece = ce; t.eaddr = addr; t.evld = vld; t.epc = pc; t.emis = mis;
        return t;
    endfunction

    // Accepted transfers: redirect and reset cycles discard the pop, so skip them.
    always @(negedge clk) begin
        if (!rst && !bus.redirect_i && bus.id_valid_o && bus.id_ready_i) begin
            n_acc++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", {32'h0, bus.id_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", {32'h0, bus.id_pc_o}, {32'h0, e});
                chk("sb_inst", bus.id_inst_o, rom_word(e));
            end
        end
    end

    initial begin
        //          rst rdy stl rdr rpc           acc apc           ce addr          vld pc            mis
        tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8,        1, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h10,       1, 32'h8,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h18,       1, 32'h10,       0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h20,       1, 32'h18,       0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 32'h0,        0));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 32'h0,        1, 32'h10,       1, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h10,       1, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h18,       1, 32'h8,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h10,       1, 32'h20,       1, 32'h10,       0));
        tv.push_back(mk(0, 1, 0, 1, 32'h40,       0, 32'h0,        1, 32'h28,       1, 32'h18,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 32'h0,        0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h48,       1, 32'h40,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h40,       1, 32'h50,       1, 32'h40,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h48,       1, 32'h50,       1, 32'h48,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h50,       0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h50,       0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 1, 32'hFFFFFFF8, 0, 32'h0,        1, 32'h58,       1, 32'h50,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFF8, 0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'hFFFFFFF8, 1, 32'h0,        1, 32'hFFFFFFF8, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h44,       0, 32'h0,        1, 32'h8,        1, 32'h0,        0));
`ifdef IF_ALIGN_CHECK_EN
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44,       0, 32'h0,        1));
        tv.push_back(mk(0, 1, 0, 1, 32'h48,       0, 32'h0,        1, 32'h44,       0, 32'h0,        1));
`else
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 1, 32'h48,       0, 32'h0,        1, 32'h48,       1, 32'h40,       0));
`endif
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h48,       0, 32'h0,        0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h48,       1, 32'h50,       1, 32'h48,       0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h58,       1, 32'h50,       0));

        rst               = 1'b1;
        bus.id_ready_i    = 1'b1;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_ce", i),    {63'h0, bus.rom_ce_o},    {63'h0, tv[i].ece});
            chk($sformatf("r%0d_addr", i),  {32'h0, bus.rom_addr_o},  {32'h0, tv[i].eaddr});
            chk($sformatf("r%0d_valid", i), {63'h0, bus.id_valid_o},  {63'h0, tv[i].evld});
            chk($sformatf("r%0d_id_pc", i), {32'h0, bus.id_pc_o},     {32'h0, tv[i].epc});
            chk($sformatf("r%0d_id_inst", i), bus.id_inst_o,
                tv[i].evld ? rom_word(tv[i].epc) : 64'h0);
            chk($sformatf("r%0d_misalign", i), {63'h0, bus.misalign_o}, {63'h0, tv[i].emis});
            rst               = tv[i].rst;
            bus.id_ready_i    = tv[i].rdy;
            bus.stall_i       = tv[i].stall;
            bus.redirect_i    = tv[i].redir;
            bus.redirect_pc_i = tv[i].rpc;
            if (tv[i].acc) sb.push_back(tv[i].apc);
        end

        @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb_accept_count", 64'(n_acc), 64'd10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the 64-bit instruction ROM and the decode stage. It owns the program counter and drives the ROM chip-enable and byte address. It captures the combinational ROM word into a 2-entry fetch buffer and presents {pc, inst} to decode through a valid/ready handshake. It also absorbs branch/flush redirects from execute and the pipeline controller.

## Interface
- ADDR_W, 32, instruction byte-address width
- INST_W, 64, instruction width; one instruction per 8-byte slot
- RESET_PC, 0, PC loaded on reset; must be 8-byte aligned
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rom_ce_o  out  1  ROM chip enable
- rom_addr_o  out  ADDR_W  ROM byte address (= PC)
- rom_inst_i  in  INST_W  ROM data, combinational from rom_addr_o; zero when ce low
- stall_i  in  1  controller stall; suppresses new fetches only
- redirect_i  in  1  branch taken or flush
- redirect_pc_i  in  ADDR_W  new PC on redirect
- id_valid_o  out  1  buffer head valid
- id_ready_i  in  1  decode accepts head this cycle
- id_pc_o  out  ADDR_W  PC of head instruction
- id_inst_o  out  INST_W  head instruction
- misalign_o  out  1  sticky misaligned-redirect flag

## Operation
- Reset (rst=1 at edge): pc=RESET_PC, rom_ce_o=0, buffer empty, id_valid_o=0, id_pc_o=0, id_inst_o=0, misalign_o=0.
- rom_ce_o is registered: 1 from the first edge with rst=0, then held at 1.
- Fetch condition: rom_ce_o & !stall_i & !redirect_i & !misalign_o & (count<2 | pop).
- On fetch: push {pc, rom_inst_i}; pc <= pc+8, modulo 2^ADDR_W. Wrap from all-ones-minus-7 to 0 is silent.
- Pop: id_valid_o & id_ready_i. Removes the head.
- id_valid_o = (count!=0). id_pc_o/id_inst_o show the head and are zero when empty.
- Push and pop in the same cycle with count=2: allowed, count stays 2.
- Redirect has highest priority. The buffer is cleared, pc <= redirect_pc_i, and any fetch or pop in that cycle is discarded. Decode must not rely on a pop completing in a redirect cycle.
- stall_i: pc holds and no push occurs. Pops continue, so decode drains the buffer.
- Decode backpressure without stall: fetch continues until count=2, then pc holds.
- count never exceeds 2 and never underflows; pop when empty is ignored.

## Timing
- PC presented in cycle N; the instruction is visible on id_* in cycle N+1 (one-cycle fetch latency).
- Sustained throughput: 1 instruction/cycle with id_ready_i held high.
- Redirect asserted in cycle N: rom_addr_o=redirect_pc_i in N+1; that instruction is on id_* in N+2. id_valid_o=0 in N+1.
- First fetch after reset release: rst falls before edge E0. At E0 ce goes to 1, so the first fetch is in the cycle after E0 and the RESET_PC instruction is valid one cycle after that.
- Reset mid-operation discards buffer contents in that cycle.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[2:0]!=0 loads the PC unmodified and sets misalign_o.
  - Fetching halts while misalign_o=1; the buffer stays empty.
  - misalign_o clears on the next aligned redirect or on reset.
- IF_ALIGN_CHECK_EN undefined:
  - redirect_pc_i[2:0] is forced to 0 on load.
  - misalign_o is tied 0.

## Structure
- Shared defines header holds ADDR_W/INST_W defaults, RstEnable/ChipEnable/ChipDisable, ZeroWord/ZeroDoubleWord, and the PC increment constant (8).
- Sub-module if_fetch_buf: 2-entry {pc, inst} FIFO with push, pop, clear, count, and head outputs.
- The top level holds the PC, ce register, fetch-condition logic and misalign flag.

## Test plan
- Reset release, id_ready_i=1, ROM words W0..W3 at 0x0..0x18 -> id_* shows (0x0,W0),(0x8,W1),(0x10,W2) on consecutive cycles starting 2 cycles after reset release.
- id_ready_i=0 for 5 cycles -> count saturates at 2 and pc holds at 0x10. On release, W0, W1, W2 arrive in order with no loss or duplicate.
- redirect_i=1 with redirect_pc_i=0x40 while buffer full -> next cycle id_valid_o=0 and rom_addr_o=0x40; the following cycle id_* = (0x40,W8).
- stall_i=1 for 3 cycles with 2 entries buffered and ready=1 -> both drain, id_valid_o=0, pc unchanged. Fetch resumes the cycle after stall_i drops.
- pc=0xFFFFFFF8 -> after the fetch, pc=0x0 and no flag is raised.
- redirect_pc_i=0x44:
  - With IF_ALIGN_CHECK_EN -> misalign_o=1, no further id_valid_o; a redirect to 0x48 clears the flag and fetch resumes.
  - Without IF_ALIGN_CHECK_EN -> pc=0x40.
